// File: rtl/dca_lsu_rdata_tracker.sv
// Response-side tracker for matrix loads: pops one txn info per AXI read burst, counts R beats
// against it, forwards data beats with lane offset / last tags, and flags completion and errors.
//
// state    | meaning
// ST_IDLE  | no txn latched; txn_ready follows enable, R beats are not accepted
// ST_BURST | txn latched; R beats counted against alen, forwarded or dropped (skip)
module dca_lsu_rdata_tracker #(
  parameter int BW_BITADDR  = 32,
  parameter int BW_AXI_DATA = 32,
  parameter int BW_ALEN     = 8,
  parameter int BW_TXN_INFO = BW_BITADDR + BW_ALEN + 2,
  localparam int BW_OFFSET  = (BW_AXI_DATA > 8) ? $clog2(BW_AXI_DATA / 8) : 1
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   clear,
  input  logic                   enable,
  output logic                   txn_ready,
  input  logic                   txn_valid,
  input  logic [BW_TXN_INFO-1:0] txn_info,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [BW_AXI_DATA-1:0] rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [BW_AXI_DATA-1:0] odata,
  output logic [BW_OFFSET-1:0]   ooffset,
  output logic                   olast,
  output logic                   done,
  output logic                   err_rlast,
  output logic                   err_resp
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t               state;
  logic [BW_ALEN-1:0]   beat_cnt;
  logic                 cur_cmd_last;
  logic                 cur_skip;
  logic [BW_ALEN-1:0]   cur_alen;
  logic [BW_OFFSET-1:0] cur_offset;
  logic                 done_q;

  logic [BW_BITADDR-1:0] txn_bitaddr;
  logic [BW_ALEN-1:0]    txn_alen;
  logic                  txn_skip;
  logic                  txn_cmd_last;
  logic [BW_OFFSET-1:0]  txn_offset;
  logic                  unused_bitaddr;

  logic live;
  logic in_burst;
  logic cnt_at_alen;
  logic beat_acc;
  logic final_beat;
  logic txn_acc;

  assign txn_bitaddr  = txn_info[BW_BITADDR-1:0];
  assign txn_alen     = txn_info[BW_BITADDR +: BW_ALEN];
  assign txn_skip     = txn_info[BW_BITADDR + BW_ALEN];
  assign txn_cmd_last = txn_info[BW_BITADDR + BW_ALEN + 1];
  // An 8-bit bus has a single byte lane, so the offset degenerates to a constant zero.
  assign txn_offset   = (BW_AXI_DATA > 8) ? txn_bitaddr[3 +: BW_OFFSET] : '0;
  assign unused_bitaddr = ^txn_bitaddr;

  // Handshake outputs are suppressed in reset, during clear and while stalled.
  assign live        = enable & ~clear & rstnn;
  assign in_burst    = (state == ST_BURST);
  assign cnt_at_alen = (beat_cnt == cur_alen);

  assign rready     = live & in_burst & (cur_skip | oready);
  assign ovalid     = live & in_burst & ~cur_skip & rvalid;
  assign beat_acc   = rvalid & rready;
  assign final_beat = beat_acc & cnt_at_alen;
  // In a burst the next txn is only taken together with the final beat, so bursts chain with no bubble.
  assign txn_ready  = live & (~in_burst | (final_beat & txn_valid));
  assign txn_acc    = txn_ready & txn_valid;

  assign odata   = rdata;
  assign olast   = ovalid & cnt_at_alen;
  assign ooffset = (ovalid && beat_cnt == '0) ? cur_offset : '0;
  assign done    = done_q & enable;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      cur_cmd_last <= 1'b0;
      cur_skip     <= 1'b0;
      cur_alen     <= '0;
      cur_offset   <= '0;
      done_q       <= 1'b0;
      err_rlast    <= 1'b0;
      err_resp     <= 1'b0;
    end else if (clear) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      cur_cmd_last <= 1'b0;
      cur_skip     <= 1'b0;
      cur_alen     <= '0;
      cur_offset   <= '0;
      done_q       <= 1'b0;
      err_rlast    <= 1'b0;
      err_resp     <= 1'b0;
    end else if (enable) begin
      done_q <= final_beat & cur_cmd_last;
      if (beat_acc) begin
        if (rresp != 2'b00) begin
          err_resp <= 1'b1;
        end
        // The count decides where the burst ends; rlast is only cross-checked.
        if (rlast != cnt_at_alen) begin
          err_rlast <= 1'b1;
        end
        if (!cnt_at_alen) begin
          beat_cnt <= beat_cnt + BW_ALEN'(1);
        end
      end
      if (txn_acc) begin
        state        <= ST_BURST;
        beat_cnt     <= '0;
        cur_cmd_last <= txn_cmd_last;
        cur_skip     <= txn_skip;
        cur_alen     <= txn_alen;
        cur_offset   <= txn_offset;
      end else if (final_beat) begin
        state <= ST_IDLE;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

endmodule
